// File: rtl/dm_types_pkg.sv
// Shared data-memory types: access width codes, unit FSM states and lane helpers.
package dm_types_pkg;

    typedef enum logic [2:0] {
        DT_WORD  = 3'd0,
        DT_HALF  = 3'd1,
        DT_HALFU = 3'd2,
        DT_BYTE  = 3'd3,
        DT_BYTEU = 3'd4
    } dt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Raw type field to enum; undefined codes behave as a full word.
    function automatic dt_e decode_dt(input logic [2:0] code);
        case (code)
            3'd1:    return DT_HALF;
            3'd2:    return DT_HALFU;
            3'd3:    return DT_BYTE;
            3'd4:    return DT_BYTEU;
            default: return DT_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input dt_e dt, input logic [1:0] lo);
        case (dt)
            DT_WORD:           return lo != 2'b00;
            DT_HALF, DT_HALFU: return lo[0];
            default:           return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_enable(input dt_e dt, input logic [1:0] lo);
        case (dt)
            DT_HALF, DT_HALFU: return lo[1] ? 4'b1100 : 4'b0011;
            DT_BYTE, DT_BYTEU: return 4'b0001 << lo;
            default:           return 4'b1111;
        endcase
    endfunction

    // Replicate store data across all lanes so the byte enables alone pick the target.
    function automatic logic [31:0] replicate(input dt_e dt, input logic [31:0] d);
        case (dt)
            DT_HALF, DT_HALFU: return {2{d[15:0]}};
            DT_BYTE, DT_BYTEU: return {4{d[7:0]}};
            default:           return d;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed lane of a read word and sign/zero-extends it to 32 bits.
module load_extend
    import dm_types_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  dt_e         dtype,
    output logic [31:0] result
);

    logic [15:0] half_lane;
    logic [7:0]  byte_lane;

    // Lane selection from the low address bits.
    always_comb begin
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
    end

    // Extension according to the access type.
    always_comb begin
        case (dtype)
            DT_HALF:  result = {{16{half_lane[15]}}, half_lane};
            DT_HALFU: result = {16'h0000, half_lane};
            DT_BYTE:  result = {{24{byte_lane[7]}}, byte_lane};
            DT_BYTEU: result = {24'h000000, byte_lane};
            default:  result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// EX/MEM consumer: runs one load/store on the req/ack data bus and stalls until it ends.
module mem_access_unit
    import dm_types_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iALUOut,
    input  logic [31:0] iRTData,
    input  logic        iDMWriteEnable,
    input  logic        iDMReadEnable,
    input  logic [2:0]  iDMDataType,
    output logic        oStall,
    output logic        oBusReq,
    output logic        oBusWe,
    output logic [31:0] oBusAddr,
    output logic [3:0]  oBusByteEn,
    output logic [31:0] oBusWData,
    input  logic        iBusAck,
    input  logic [31:0] iBusRData,
    output logic [31:0] oLoadData,
    output logic        oLoadValid,
    output logic        oAddrExc,
    output logic        oBusErr
);

    // Counter value seen in the last BUSY cycle allowed before the abort.
    localparam logic [WAIT_W-1:0] LastWait = WAIT_W'(MAX_WAIT - 1);

    state_e            state;
    dt_e               dt_q;
    logic [1:0]        addr_lo_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic        access;
    dt_e         dt_in;
    logic        misaligned;
    logic [31:0] ext_data;

    // Decode of the incoming EX/MEM op.
    always_comb begin
        access     = iDMWriteEnable | iDMReadEnable;
        dt_in      = decode_dt(iDMDataType);
        misaligned = is_misaligned(dt_in, iALUOut[1:0]);
    end

    load_extend u_load_extend (
        .rdata   (iBusRData),
        .addr_lo (addr_lo_q),
        .dtype   (dt_q),
        .result  (ext_data)
    );

    // Stall covers the accepting IDLE cycle and every BUSY cycle; gated off during reset.
    always_comb begin
        oStall   = reset & (((state == ST_IDLE) & access & ~misaligned) | (state == ST_BUSY));
        oAddrExc = reset & (state == ST_IDLE) & access & misaligned;
    end

    // Access FSM with registered bus and result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            dt_q       <= DT_WORD;
            addr_lo_q  <= 2'b00;
            wait_cnt   <= '0;
            oBusReq    <= 1'b0;
            oBusWe     <= 1'b0;
            oBusAddr   <= 32'h0;
            oBusByteEn <= 4'h0;
            oBusWData  <= 32'h0;
            oLoadData  <= 32'h0;
            oLoadValid <= 1'b0;
            oBusErr    <= 1'b0;
        end else begin
            oLoadValid <= 1'b0;
            oBusErr    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (access && !misaligned) begin
                        state      <= ST_BUSY;
                        oBusReq    <= 1'b1;
                        oBusWe     <= iDMWriteEnable;
                        oBusAddr   <= {iALUOut[31:2], 2'b00};
                        oBusByteEn <= lane_enable(dt_in, iALUOut[1:0]);
                        oBusWData  <= replicate(dt_in, iRTData);
                        dt_q       <= dt_in;
                        addr_lo_q  <= iALUOut[1:0];
                        wait_cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (iBusAck) begin
                        state   <= ST_DONE;
                        oBusReq <= 1'b0;
                        if (!oBusWe) begin
                            oLoadData  <= ext_data;
                            oLoadValid <= 1'b1;
                        end
                    end else if (wait_cnt == LastWait) begin
                        state   <= ST_DONE;
                        oBusReq <= 1'b0;
                        oBusErr <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
